// File: rtl/pdm_multi.sv
// pdm_multi: NCH-channel first-order PDM sharing one prescaler.
// A double-buffered code set lets all channels retune on the same tick.
module pdm_multi #(
  parameter int NBITS     = 10,
  parameter int NCH       = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*NBITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [NCH-1:0]       en,
  output logic [NCH-1:0]       dout,
  output logic [NCH*NBITS-1:0] error,
  output logic                 strobe
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [NCH*NBITS-1:0] r_shadow;
  logic [NCH*NBITS-1:0] r_active;
  logic                 r_pending;
  logic                 r_strobe;

  logic                 w_tick;
  logic                 w_xfer;
  logic [NCH*NBITS-1:0] w_oper;

  // >= rather than == so lowering div below cnt ticks at once
  assign w_tick    = (r_cnt >= div);
  assign w_xfer    = din_valid & ~r_pending;
  assign w_oper    = r_pending ? r_shadow : r_active;
  assign din_ready = ~r_pending;
  assign strobe    = r_strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
      r_strobe <= w_tick;
    end
  end

  // xfer needs !pending, so the two branches never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_shadow  <= din;
      r_pending <= 1'b1;
    end else if (w_tick && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             r_d;
    logic [NBITS-1:0] r_e;
    logic [NBITS:0]   w_sum;

    assign w_sum = {1'b0, r_e} + {1'b0, w_oper[g*NBITS +: NBITS]};
    assign dout[g] = r_d;
    assign error[g*NBITS +: NBITS] = r_e;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_d <= 1'b0;
        r_e <= '0;
      end else if (!en[g]) begin
        r_d <= 1'b0;
        r_e <= '0;
      end else if (w_tick) begin
        {r_d, r_e} <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_pdm_multi.sv
// tb_pdm_multi: closed-form density tables, directed handshake/enable/reset
// sequences and a randomized run against an arithmetic reference model.
module tb_pdm_multi;

  logic        clk;
  logic        rst;
  logic [39:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  div;
  logic [3:0]  en;
  logic [3:0]  dout;
  logic [39:0] error;
  logic        strobe;

  pdm_multi #(.NBITS(10), .NCH(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .div(div), .en(en), .dout(dout),
    .error(error), .strobe(strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  // reference model: plain integer state per the modulator rules
  int m_cnt;
  bit m_pend;
  bit m_stb;
  int m_sh[4];
  int m_ac[4];
  int m_err[4];
  bit m_dout[4];

  typedef struct {
    int code[4];
    int ticks;
    int ones[4];
    int err[4];
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_stb = 0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 0; m_ac[i] = 0; m_err[i] = 0; m_dout[i] = 0;
    end
  endtask

  task automatic step();
    bit t;
    bit x;
    int op;
    int s;
    t = (m_cnt >= int'(div));
    x = din_valid && !m_pend;
    for (int i = 0; i < 4; i++) begin
      if (!en[i]) begin
        m_dout[i] = 0; m_err[i] = 0;
      end else if (t) begin
        op = m_pend ? m_sh[i] : m_ac[i];
        s = m_err[i] + op;
        m_dout[i] = (s >= 1024);
        m_err[i] = s % 1024;
      end
    end
    if (t && m_pend) begin
      for (int i = 0; i < 4; i++) m_ac[i] = m_sh[i];
      m_pend = 0;
    end
    if (x) begin
      for (int i = 0; i < 4; i++) m_sh[i] = int'(din[i*10 +: 10]);
      m_pend = 1;
    end
    m_cnt = t ? 0 : m_cnt + 1;
    m_stb = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    logic [3:0]  ed;
    logic [39:0] ee;
    for (int i = 0; i < 4; i++) begin
      ed[i] = m_dout[i];
      ee[i*10 +: 10] = m_err[i][9:0];
    end
    chk(nm, {18'd0, dout, error, strobe, din_ready},
        {18'd0, ed, ee, m_stb, !m_pend});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_din(input int c0, input int c1,
                         input int c2, input int c3);
    din = {c3[9:0], c2[9:0], c1[9:0], c0[9:0]};
  endtask

  task automatic load(input int c0, input int c1,
                      input int c2, input int c3);
    set_din(c0, c1, c2, c3);
    for (int k = 0; k < 600 && !din_ready; k++) step();
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 600 && !din_ready; k++) step();
    chk("load_done", din_ready, 1);
  endtask

  initial begin
    int ones[4];
    int got;
    int bad;
    int nstb;
    int last;
    int prev;
    int eb;

    tbl[0] = '{'{120, 500, 900, 1023}, 1024,
               '{120, 500, 900, 1023}, '{0, 0, 0, 0}};
    tbl[1] = '{'{0, 1, 512, 1000}, 100,
               '{0, 0, 50, 97}, '{0, 100, 0, 672}};
    tbl[2] = '{'{120, 1023, 333, 7}, 37,
               '{4, 36, 12, 0}, '{344, 987, 33, 259}};

    rst = 1'b1; din = '0; din_valid = 1'b0; div = '0; en = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_state", {dout, error, strobe, din_ready}, {45'd0, 1'b1});
    rst = 1'b0;

    // density tables: div=0, enable after codes are active
    for (int r = 0; r < 3; r++) begin
      do_reset();
      div = 8'd0; en = 4'h0;
      load(tbl[r].code[0], tbl[r].code[1], tbl[r].code[2], tbl[r].code[3]);
      en = 4'hF;
      for (int i = 0; i < 4; i++) ones[i] = 0;
      for (int k = 0; k < tbl[r].ticks; k++) begin
        step();
        for (int i = 0; i < 4; i++) ones[i] += int'(dout[i]);
      end
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tbl%0d_ones%0d", r, i), ones[i], tbl[r].ones[i]);
        chk($sformatf("tbl%0d_err%0d", r, i), error[i*10 +: 10],
            tbl[r].err[i]);
      end
    end

    // prescaled: div=3, ch0=120 over 4096 clocks
    do_reset();
    div = 8'd3; en = 4'h0;
    load(120, 0, 0, 0);
    en = 4'hF;
    ones[0] = 0; bad = 0; nstb = 0; last = -1; prev = int'(dout[0]);
    for (int k = 0; k < 4096; k++) begin
      step();
      if (strobe) begin
        nstb++;
        ones[0] += int'(dout[0]);
        if (last >= 0 && k - last != 4) bad++;
        last = k;
      end else if (int'(dout[0]) != prev) begin
        bad++;
      end
      prev = int'(dout[0]);
    end
    chk("div3_ones", ones[0], 120);
    chk("div3_strobes", nstb, 1024);
    chk("div3_timing", bad, 0);

    // handshake, div=9: A pending, B held until A's tick
    do_reset();
    div = 8'd9; en = 4'hF;
    set_din(100, 200, 300, 400);
    din_valid = 1'b1;
    step();
    chk("ready_fall", din_ready, 0);
    set_din(50, 60, 70, 80);
    got = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      chk_model("hs_wait");
      if (din_ready) begin
        got = 1;
        break;
      end
    end
    chk("a_tick_ready", got, 1);
    chk("a_tick_strobe", strobe, 1);
    chk("a_all_ch", error, {10'd400, 10'd300, 10'd200, 10'd100});
    step();
    chk("b_taken", din_ready, 0);
    din_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      chk_model("hs_b");
    end

    // enable drop and restart on ch2
    do_reset();
    div = 8'd0; en = 4'hF;
    load(77, 300, 613, 999);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_model("en_run");
    end
    en = 4'b1011;
    step();
    chk("en_drop_dout", dout[2], 0);
    chk("en_drop_err", error[29:20], 0);
    chk_model("en_drop");
    for (int k = 0; k < 5; k++) begin
      step();
      chk_model("en_off");
    end
    en = 4'hF;
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      chk_model("en_back");
      eb = (k * 613) / 1024 - ((k - 1) * 613) / 1024;
      if (int'(dout[2]) != eb) bad++;
    end
    chk("reenable_seq", bad, 0);
    chk("reenable_err", error[29:20], (64 * 613) % 1024);

    // asynchronous reset between edges with a word pending
    do_reset();
    div = 8'd0; en = 4'hF;
    load(1000, 900, 800, 700);
    for (int k = 0; k < 10; k++) step();
    div = 8'd9;
    set_din(1023, 1023, 1023, 1023);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_outs", {dout, error, strobe}, 45'd0);
    chk("arst_ready", din_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ones[0] = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      chk_model("arst_after");
      ones[0] += int'(dout != 4'h0);
    end
    chk("arst_discard", ones[0], 0);

    // randomized run against the model
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      div = 8'($urandom_range(0, 12));
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 7) == 0) en = 4'($urandom_range(0, 15));
        else en = 4'hF;
        if (!(din_valid && !din_ready)) begin
          din_valid = ($urandom_range(0, 3) == 0);
          din = 40'({$urandom(), $urandom()});
        end
        step();
        chk_model("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
